// File: rtl/ascii_hex_number_parser.sv
// ASCII hex operand parser: collects hex digits from a byte stream and presents
// the operand, digit count and error flags once the delimiter byte arrives.
module ascii_hex_number_parser #(
  parameter int unsigned N_DIGITS = 8,
  parameter logic [7:0]  DLM_CHAR = 8'h0D,
  parameter bit          LOWER_EN = 1'b1,
  localparam int unsigned W  = 4 * N_DIGITS,
  localparam int unsigned CW = $clog2(N_DIGITS + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_in_valid,
  input  logic [7:0]    i_in_data,
  output logic          o_in_ready_c,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [W-1:0]  o_out_data,
  output logic [CW-1:0] o_out_ndig,
  output logic          o_err_char,
  output logic          o_err_ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_err_char;
  logic            r_err_ovf;

  state_t          w_state_nxt;
  logic [W-1:0]    w_acc_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_err_char_nxt;
  logic            w_err_ovf_nxt;

  logic            w_accept;
  logic            w_is_dlm;
  logic            w_is_hex;
  logic [3:0]      w_nib;
  logic [W-1:0]    w_shifted;
  logic            w_full;

  // Byte is taken whenever we are out of reset/abort and not holding a result.
  assign o_in_ready_c = i_rst_n & ~i_clr & (r_state != S_DONE);
  assign w_accept     = i_in_valid & o_in_ready_c;
  assign w_is_dlm     = (i_in_data == DLM_CHAR);
  assign w_full       = (r_cnt == CW'(N_DIGITS));
  // Low W bits of {acc, nib} drop the oldest nibble; also correct for one digit.
  assign w_shifted    = W'({r_acc, w_nib});

  // ASCII to nibble decode.
  always_comb begin
    w_is_hex = 1'b0;
    w_nib    = 4'd0;
    if (i_in_data >= 8'h30 && i_in_data <= 8'h39) begin
      w_is_hex = 1'b1;
      w_nib    = 4'(i_in_data - 8'h30);
    end else if (i_in_data >= 8'h41 && i_in_data <= 8'h46) begin
      w_is_hex = 1'b1;
      w_nib    = 4'(i_in_data - 8'h37);
    end else if (LOWER_EN && i_in_data >= 8'h61 && i_in_data <= 8'h66) begin
      w_is_hex = 1'b1;
      w_nib    = 4'(i_in_data - 8'h57);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt    = r_state;
    w_acc_nxt      = r_acc;
    w_cnt_nxt      = r_cnt;
    w_err_char_nxt = r_err_char;
    w_err_ovf_nxt  = r_err_ovf;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept && !w_is_dlm) begin
          if (w_is_hex) begin
            w_acc_nxt   = w_shifted;
            w_cnt_nxt   = CW'(1);
            w_state_nxt = S_ACC;
          end else begin
            w_err_char_nxt = 1'b1;
            w_state_nxt    = S_DRAIN;
          end
        end
      end
      S_ACC: begin
        if (w_accept) begin
          if (w_is_dlm) begin
            w_state_nxt = S_DONE;
          end else if (w_is_hex) begin
            if (w_full) begin
              w_err_ovf_nxt = 1'b1;
              w_state_nxt   = S_DRAIN;
            end else begin
              w_acc_nxt = w_shifted;
              w_cnt_nxt = r_cnt + CW'(1);
            end
          end else begin
            w_err_char_nxt = 1'b1;
            w_state_nxt    = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (w_accept) begin
          if (w_is_dlm) begin
            w_state_nxt = S_DONE;
          end else if (!w_is_hex) begin
            w_err_char_nxt = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (i_out_ready) begin
          w_state_nxt    = S_IDLE;
          w_acc_nxt      = '0;
          w_cnt_nxt      = '0;
          w_err_char_nxt = 1'b0;
          w_err_ovf_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and accumulator registers; reset and abort both return to empty IDLE.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_err_char <= 1'b0;
      r_err_ovf  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_acc      <= w_acc_nxt;
      r_cnt      <= w_cnt_nxt;
      r_err_char <= w_err_char_nxt;
      r_err_ovf  <= w_err_ovf_nxt;
    end
  end

  assign o_out_valid = (r_state == S_DONE);
  assign o_out_data  = r_acc;
  assign o_out_ndig  = r_cnt;
  assign o_err_char  = r_err_char;
  assign o_err_ovf   = r_err_ovf;

endmodule

// File: tb/tb_ascii_hex_number_parser.sv
// Directed bench for ascii_hex_number_parser, plus model-checked random strings.
module tb_ascii_hex_number_parser;

  logic        clk = 1'b0;
  logic        rst_n, clr, in_valid, out_ready;
  logic [7:0]  in_data;

  logic        in_ready, out_valid, err_char, err_ovf;
  logic [31:0] out_data;
  logic [3:0]  out_ndig;

  logic        u_in_ready, u_out_valid, u_err_char, u_err_ovf;
  logic [31:0] u_out_data;
  logic [3:0]  u_out_ndig;

  int n_checks = 0;
  int n_errors = 0;
  bit gaps     = 1'b0;

  ascii_hex_number_parser #(.N_DIGITS(8), .DLM_CHAR(8'h0D), .LOWER_EN(1'b1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_in_valid(in_valid), .i_in_data(in_data),
    .o_in_ready_c(in_ready), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_data(out_data), .o_out_ndig(out_ndig), .o_err_char(err_char), .o_err_ovf(err_ovf)
  );

  ascii_hex_number_parser #(.N_DIGITS(8), .DLM_CHAR(8'h0D), .LOWER_EN(1'b0)) u_dut_uc (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_in_valid(in_valid), .i_in_data(in_data),
    .o_in_ready_c(u_in_ready), .o_out_valid(u_out_valid), .i_out_ready(out_ready),
    .o_out_data(u_out_data), .o_out_ndig(u_out_ndig), .o_err_char(u_err_char), .o_err_ovf(u_err_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    if (gaps) repeat ($urandom_range(0, 2)) step();
    in_valid = 1'b1;
    in_data  = b;
    #1;
    while (!in_ready && guard < 100) begin
      step();
      guard++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic wait_valid(input string tag, output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    chk({tag, "_valid"}, 64'(out_valid), 64'(1));
  endtask

  task automatic expect_res(input string tag, input logic [31:0] d, input logic [3:0] n,
                            input bit ec, input bit eo);
    int lat;
    wait_valid(tag, lat);
    chk({tag, "_lat"}, 64'(lat), 64'(0));
    chk({tag, "_data"}, 64'(out_data), 64'(d));
    chk({tag, "_ndig"}, 64'(out_ndig), 64'(n));
    chk({tag, "_echar"}, 64'(err_char), 64'(ec));
    chk({tag, "_eovf"}, 64'(err_ovf), 64'(eo));
    chk({tag, "_inrdy0"}, 64'(in_ready), 64'(0));
    if (gaps) repeat ($urandom_range(0, 3)) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_drop"}, 64'(out_valid), 64'(0));
    chk({tag, "_inrdy1"}, 64'(in_ready), 64'(1));
  endtask

  function automatic int hexval(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
    return -1;
  endfunction

  // Byte-level reference: first error stops accumulation, later non-hex bytes still flag.
  function automatic void model(input string s, output logic [31:0] d, output logic [3:0] n,
                                output bit ec, output bit eo);
    int v;
    d = '0; n = '0; ec = 1'b0; eo = 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      v = hexval(s[i]);
      if (v < 0) ec = 1'b1;
      else if (!ec && !eo) begin
        if (n == 4'd8) eo = 1'b1;
        else begin
          d = {d[27:0], 4'(v)};
          n = n + 4'd1;
        end
      end
    end
  endfunction

  initial begin
    string       s;
    string       alphabet;
    logic [31:0] md;
    logic [3:0]  mn;
    bit          mec, meo;
    int          lat;
    logic [7:0]  ch;

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    #1;
    chk("rst_inrdy", 64'(in_ready), 64'(0));
    step(); step();
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_ndig", 64'(out_ndig), 64'(0));
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_flags", 64'({err_char, err_ovf}), 64'(0));
    rst_n = 1'b1;
    step();
    chk("idle_inrdy", 64'(in_ready), 64'(1));

    send_str("1A2b"); send_byte(8'h0D);
    expect_res("t1", 32'h00001A2B, 4'd4, 1'b0, 1'b0);

    send_str("FFFFFFFF"); send_byte(8'h0D);
    expect_res("t2_full", 32'hFFFFFFFF, 4'd8, 1'b0, 1'b0);
    send_str("123456789"); send_byte(8'h0D);
    expect_res("t2_ovf", 32'h12345678, 4'd8, 1'b0, 1'b1);

    send_str("1G2"); send_byte(8'h0D);
    expect_res("t3_char", 32'h00000001, 4'd1, 1'b1, 1'b0);
    send_byte(8'h0D);
    for (int i = 0; i < 3; i++) begin
      chk("t3_bare_dlm", 64'(out_valid), 64'(0));
      step();
    end
    send_str("123456789G"); send_byte(8'h0D);
    expect_res("t3_both", 32'h12345678, 4'd8, 1'b1, 1'b1);

    send_str("7E"); send_byte(8'h0D);
    wait_valid("t4_hold", lat);
    in_valid = 1'b1; in_data = 8'h35;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_inrdy", 64'(in_ready), 64'(0));
      chk("t4_data", 64'(out_data), 64'(32'h7E));
      chk("t4_valid", 64'(out_valid), 64'(1));
    end
    in_valid = 1'b0;
    expect_res("t4", 32'h0000007E, 4'd2, 1'b0, 1'b0);
    send_str("5"); send_byte(8'h0D);
    expect_res("t4_next", 32'h00000005, 4'd1, 1'b0, 1'b0);

    send_str("AB");
    clr = 1'b1; in_valid = 1'b1; in_data = 8'h39;
    #1;
    chk("t5_clr_inrdy", 64'(in_ready), 64'(0));
    step();
    clr = 1'b0; in_valid = 1'b0;
    chk("t5_clr_data", 64'(out_data), 64'(0));
    chk("t5_clr_ndig", 64'(out_ndig), 64'(0));
    send_str("C"); send_byte(8'h0D);
    expect_res("t5_clr", 32'h0000000C, 4'd1, 1'b0, 1'b0);

    send_str("12");
    rst_n = 1'b0;
    #1;
    chk("t5_rst_inrdy", 64'(in_ready), 64'(0));
    step();
    chk("t5_rst_data", 64'(out_data), 64'(0));
    chk("t5_rst_ndig", 64'(out_ndig), 64'(0));
    rst_n = 1'b1;
    step();
    send_str("3G"); send_byte(8'h0D);
    wait_valid("t5_rst_done", lat);
    rst_n = 1'b0;
    step();
    chk("t5_rst_done_valid", 64'(out_valid), 64'(0));
    chk("t5_rst_done_flags", 64'({err_char, err_ovf}), 64'(0));
    rst_n = 1'b1;
    step();

    send_str("ab"); send_byte(8'h0D);
    wait_valid("t6_lc", lat);
    chk("t6_uc_valid", 64'(u_out_valid), 64'(1));
    chk("t6_uc_echar", 64'(u_err_char), 64'(1));
    chk("t6_uc_ndig", 64'(u_out_ndig), 64'(0));
    chk("t6_uc_data", 64'(u_out_data), 64'(0));
    expect_res("t6_lc", 32'h000000AB, 4'd2, 1'b0, 1'b0);

    gaps = 1'b1;
    alphabet = "0123456789ABCDEFabcdefGx";
    for (int t = 0; t < 20; t++) begin
      s = "";
      repeat ($urandom_range(1, 11)) begin
        ch = alphabet[$urandom_range(0, alphabet.len() - 1)];
        s  = $sformatf("%s%c", s, ch);
      end
      model(s, md, mn, mec, meo);
      send_str(s); send_byte(8'h0D);
      expect_res($sformatf("rnd%0d", t), md, mn, mec, meo);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
